// File: rtl/encoder_pkg.sv
// Shared types and helpers for the priority scan encoder and its
// combinational priority stage.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index width for an n-entry vector, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

  localparam int DEFAULT_N = 8;
  localparam int DEFAULT_W = clog2_min1(DEFAULT_N);

  typedef logic [DEFAULT_W-1:0] code_t;

endpackage

// File: rtl/prio_enc_comb.sv
// Purely combinational priority encoder: index of the winning set bit,
// plus any-set and exactly-one-set flags.
module prio_enc_comb
  import encoder_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);

  // The last match in scan order wins, so the scan direction sets priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Registered multi-hot priority encoder: captures a request vector and
// emits the index of each set bit, one per valid/ready handshake.
module priority_scan_encoder
  import encoder_pkg::*;
#(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W = clog2_min1(N)
) (
  input  logic         CP,
  input  logic         CR,
  input  logic         LOAD,
  input  logic [N-1:0] DATA,
  output logic         BUSY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] CODE,
  output logic         LAST,
  output logic         ZERO
);

  localparam logic [N-1:0] BIT0 = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt, pending_clr, enc_vec;
  logic [W-1:0] enc_idx, code_nxt;
  logic         enc_any, enc_single;
  logic         valid_nxt, busy_nxt, last_nxt, zero_nxt;
  logic         handshake;

  assign handshake   = OUT_VALID & OUT_READY;
  assign pending_clr = pending & ~(BIT0 << CODE);

  // Encoding the post-clear remainder lets the next code land on the
  // handshake edge itself, so there is no bubble between codes.
  assign enc_vec = (state == IDLE) ? DATA : pending_clr;

  prio_enc_comb #(
    .N        (N),
    .MSB_FIRST(MSB_FIRST)
  ) u_prio (
    .vec   (enc_vec),
    .idx   (enc_idx),
    .any   (enc_any),
    .single(enc_single)
  );

  always_ff @(posedge CP or posedge CR) begin
    if (CR) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (LOAD && enc_any) state_nxt = SCAN;
      SCAN: if (handshake && LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pending_nxt = pending;
    code_nxt    = CODE;
    last_nxt    = LAST;
    valid_nxt   = OUT_VALID;
    busy_nxt    = BUSY;
    zero_nxt    = 1'b0;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        last_nxt  = 1'b0;
        if (LOAD) begin
          if (enc_any) begin
            pending_nxt = DATA;
            code_nxt    = enc_idx;
            last_nxt    = enc_single;
            valid_nxt   = 1'b1;
            busy_nxt    = 1'b1;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (handshake) begin
          pending_nxt = pending_clr;
          if (LAST) begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            last_nxt  = 1'b0;
          end else begin
            code_nxt  = enc_idx;
            last_nxt  = enc_single;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
          end
        end
      end
      default: begin
        pending_nxt = '0;
        valid_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        last_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      pending   <= '0;
      CODE      <= '0;
      LAST      <= 1'b0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      ZERO      <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      CODE      <= code_nxt;
      LAST      <= last_nxt;
      OUT_VALID <= valid_nxt;
      BUSY      <= busy_nxt;
      ZERO      <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench: two N=8 encoders (MSB-first and LSB-first) share stimulus;
// an N=16 LSB-first encoder covers the wide case.
module tb_priority_scan_encoder;

  logic        cp = 1'b0;
  logic        cr;
  logic        load;
  logic        ready;
  logic [7:0]  data8;
  logic [15:0] data16;

  logic       h_busy, h_valid, h_last, h_zero;
  logic [2:0] h_code;
  logic       l_busy, l_valid, l_last, l_zero;
  logic [2:0] l_code;
  logic       w_busy, w_valid, w_last, w_zero;
  logic [3:0] w_code;

  int check_count = 0;
  int pass_count  = 0;

  always #5 cp = ~cp;

  priority_scan_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_hi (
    .CP(cp), .CR(cr), .LOAD(load), .DATA(data8), .BUSY(h_busy),
    .OUT_VALID(h_valid), .OUT_READY(ready), .CODE(h_code), .LAST(h_last), .ZERO(h_zero)
  );

  priority_scan_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_lo (
    .CP(cp), .CR(cr), .LOAD(load), .DATA(data8), .BUSY(l_busy),
    .OUT_VALID(l_valid), .OUT_READY(ready), .CODE(l_code), .LAST(l_last), .ZERO(l_zero)
  );

  priority_scan_encoder #(.N(16), .MSB_FIRST(1'b0)) dut_wide (
    .CP(cp), .CR(cr), .LOAD(load), .DATA(data16), .BUSY(w_busy),
    .OUT_VALID(w_valid), .OUT_READY(ready), .CODE(w_code), .LAST(w_last), .ZERO(w_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
  endtask

  // One active edge, then settle before sampling.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] d8, input logic [15:0] d16, input logic rdy);
    load   = ld;
    data8  = d8;
    data16 = d16;
    ready  = rdy;
  endtask

  // Checks both 8-bit encoders; valid/busy are common, code/last per priority order.
  task automatic checkBoth(input string tag, input logic valid, input logic busy,
                           input logic [2:0] hc, input logic hl,
                           input logic [2:0] lc, input logic ll);
    checkOutput({tag, " hi valid"}, h_valid, valid);
    checkOutput({tag, " hi busy"},  h_busy,  busy);
    checkOutput({tag, " hi code"},  h_code,  hc);
    checkOutput({tag, " hi last"},  h_last,  hl);
    checkOutput({tag, " lo valid"}, l_valid, valid);
    checkOutput({tag, " lo busy"},  l_busy,  busy);
    checkOutput({tag, " lo code"},  l_code,  lc);
    checkOutput({tag, " lo last"},  l_last,  ll);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cr = 1'b1;
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    tick();
    checkBoth("reset", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    checkOutput("reset hi zero", h_zero, 1'b0);
    checkOutput("reset wide valid", w_valid, 1'b0);
    checkOutput("reset wide code", w_code, 4'd0);
    #2 cr = 1'b0;
    tick();

    // Single bit 0: one code, then back to idle.
    applyStimulus(1'b1, 8'h01, 16'h0000, 1'b1);
    tick();
    load = 1'b0;
    checkBoth("t1 load01", 1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1);
    tick();
    checkBoth("t1 done", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);

    // One-hot sweep, each reloaded right after BUSY falls.
    for (int k = 1; k < 8; k++) begin
      applyStimulus(1'b1, 8'(1 << k), 16'h0000, 1'b1);
      tick();
      load = 1'b0;
      checkBoth($sformatf("t2 onehot%0d", k), 1'b1, 1'b1, 3'(k), 1'b1, 3'(k), 1'b1);
      tick();
      checkBoth($sformatf("t2 idle%0d", k), 1'b0, 1'b0, 3'(k), 1'b0, 3'(k), 1'b0);
    end

    // Multi-hot A5 streamed back to back.
    applyStimulus(1'b1, 8'hA5, 16'h0000, 1'b1);
    tick();
    load = 1'b0;
    checkBoth("t3 c1", 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0);
    tick();
    checkBoth("t3 c2", 1'b1, 1'b1, 3'd5, 1'b0, 3'd2, 1'b0);
    tick();
    checkBoth("t3 c3", 1'b1, 1'b1, 3'd2, 1'b0, 3'd5, 1'b0);
    tick();
    checkBoth("t3 c4", 1'b1, 1'b1, 3'd0, 1'b1, 3'd7, 1'b1);
    tick();
    checkBoth("t3 idle", 1'b0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0);

    // Backpressure on 81: first code holds, then the last one.
    applyStimulus(1'b1, 8'h81, 16'h0000, 1'b0);
    tick();
    load = 1'b0;
    checkBoth("t4 first", 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkBoth($sformatf("t4 hold%0d", k), 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0);
    end
    ready = 1'b1;
    tick();
    checkBoth("t4 second", 1'b1, 1'b1, 3'd0, 1'b1, 3'd7, 1'b1);
    tick();
    checkBoth("t4 idle", 1'b0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0);

    // All-zero load: single ZERO pulse, no scan.
    applyStimulus(1'b1, 8'h00, 16'h0000, 1'b1);
    tick();
    load = 1'b0;
    checkOutput("t5 hi zero", h_zero, 1'b1);
    checkOutput("t5 lo zero", l_zero, 1'b1);
    checkBoth("t5 zero", 1'b0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0);
    tick();
    checkOutput("t5 hi zero off", h_zero, 1'b0);
    checkOutput("t5 lo zero off", l_zero, 1'b0);

    // LOAD of FF during a scan of 30, held through the final handshake.
    applyStimulus(1'b1, 8'h30, 16'h0000, 1'b1);
    tick();
    checkBoth("t5 scan c1", 1'b1, 1'b1, 3'd5, 1'b0, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'hFF, 16'h0000, 1'b1);
    tick();
    checkBoth("t5 scan c2", 1'b1, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1);
    tick();
    load = 1'b0;
    checkBoth("t5 ignored", 1'b0, 1'b0, 3'd4, 1'b0, 3'd5, 1'b0);
    checkOutput("t5 no zero", h_zero, 1'b0);
    tick();
    checkBoth("t5 still idle", 1'b0, 1'b0, 3'd4, 1'b0, 3'd5, 1'b0);

    // Wide encoder, LSB first.
    applyStimulus(1'b1, 8'h00, 16'h8001, 1'b1);
    tick();
    load = 1'b0;
    checkOutput("t6 wide valid1", w_valid, 1'b1);
    checkOutput("t6 wide code1", w_code, 4'd0);
    checkOutput("t6 wide last1", w_last, 1'b0);
    tick();
    checkOutput("t6 wide code2", w_code, 4'd15);
    checkOutput("t6 wide last2", w_last, 1'b1);
    tick();
    checkOutput("t6 wide idle", w_valid, 1'b0);
    checkOutput("t6 wide busy", w_busy, 1'b0);

    // Asynchronous reset mid-scan of F0, then a fresh load.
    applyStimulus(1'b1, 8'hF0, 16'h0000, 1'b1);
    tick();
    load = 1'b0;
    checkBoth("t6 pre-reset", 1'b1, 1'b1, 3'd7, 1'b0, 3'd4, 1'b0);
    #1 cr = 1'b1;
    #1;
    checkBoth("t6 async reset", 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    #1 cr = 1'b0;
    applyStimulus(1'b1, 8'h02, 16'h0000, 1'b1);
    tick();
    load = 1'b0;
    checkBoth("t6 reload", 1'b1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1);
    tick();
    checkBoth("t6 reload idle", 1'b0, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
